echo_request_arbiter: RTL and testbench
=======================================

Name: echo_request_arbiter

Overview:
- Shares one Echo request/indication port pair between NUM_CLIENTS requesters.
- Request side: round-robin arbitration of say/say2 calls onto the single Echo request port.
- Response side: records each granted call's client ID and kind in an in-order tag FIFO, then steers Echo's heard/heard2 indications back to the originating client.
- Sits between the host-side request fan-in and the Echo block.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- TAG_DEPTH, 4, maximum outstanding calls; power of two.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- cli_say_ena  in  NUM_CLIENTS  per-client say request.
- cli_say_v  in  32*NUM_CLIENTS  say payload; client i at bits [32i+31:32i].
- cli_say2_ena  in  NUM_CLIENTS  per-client say2 request.
- cli_say2_a, cli_say2_b  in  16*NUM_CLIENTS each  say2 payload.
- cli_say_rdy, cli_say2_rdy  out  NUM_CLIENTS each  accept strobes.
- echo_say_ena  out  1;  echo_say_v  out  32;  echo_say_rdy  in  1.
- echo_say2_ena  out  1;  echo_say2_a, echo_say2_b  out  16 each;  echo_say2_rdy  in  1.
- echo_heard_ena  in  1;  echo_heard_v  in  32;  echo_heard_rdy  out  1.
- echo_heard2_ena  in  1;  echo_heard2_a, echo_heard2_b  in  16 each;  echo_heard2_rdy  out  1.
- cli_heard_ena  out  NUM_CLIENTS;  cli_heard_v  out  32, broadcast to all clients;  cli_heard_rdy  in  NUM_CLIENTS.
- cli_heard2_ena  out  NUM_CLIENTS;  cli_heard2_a, cli_heard2_b  out  16 each, broadcast;  cli_heard2_rdy  in  NUM_CLIENTS.
- inflight  out  clog2(TAG_DEPTH)+1  registered outstanding-call count.

Behaviour:
- Handshake: ENA/RDY method style. A transfer occurs in a cycle where ena && rdy. ENA must not depend combinationally on RDY.
- State registers:
  - rr_ptr: clog2(NUM_CLIENTS) bits.
  - Tag FIFO of TAG_DEPTH entries, each {id, kind}; kind 0 = say, 1 = say2.
  - wr_ptr, rd_ptr, count.
- Requesting client: i is requesting when cli_say_ena[i] | cli_say2_ena[i].
- Winner: first requesting client scanning rr_ptr, rr_ptr+1, ... modulo NUM_CLIENTS.
- Full: full = (count == TAG_DEPTH), taken from the registered count. A pop in the same cycle does NOT unblock a grant.
- cli_say_rdy[i] = (winner == i) && !full && echo_say_rdy.
- cli_say2_rdy[i] = (winner == i) && !cli_say_ena[i] && !full && echo_say2_rdy. Say has priority within a client; say2 waits.
- Only one of echo_say_ena / echo_say2_ena is asserted per cycle. Downstream data is the winner's payload, passed combinationally (0-cycle latency). Non-selected outputs drive 0.
- On a grant (fire):
  - push {winner, kind} at wr_ptr; wr_ptr++ (wraps at TAG_DEPTH);
  - rr_ptr <= (winner + 1) mod NUM_CLIENTS.
- If the winner's target downstream RDY is low: no grant, rr_ptr holds, and no lower-priority client is substituted.
- Response routing, with head = FIFO entry at rd_ptr and empty = (count == 0):
  - echo_heard_rdy = !empty && head.kind == 0 && cli_heard_rdy[head.id].
  - cli_heard_ena[i] = echo_heard_ena && !empty && head.kind == 0 && head.id == i.
  - heard2 is symmetric with kind == 1.
  - Pop (rd_ptr++) on echo_heard_ena && echo_heard_rdy, or on the heard2 equivalent. Only one pop per cycle.
- Kind mismatch: e.g. heard arrives while head.kind == 1. RDY stays low and Echo holds the indication; no pop, no error flag.
- Simultaneous push and pop: both occur and count is unchanged. Otherwise count += push, count -= pop.
- inflight = count, registered, so it updates the cycle after the event.
- Reset (RST high at a CLK edge):
  - rr_ptr, wr_ptr, rd_ptr, count all set to 0, and outstanding tags are discarded.
  - All rdy/ena outputs are 0 while no client requests and the FIFO is empty. inflight = 0.
  - Reset mid-operation drops in-flight tags. The Echo block is reset in the same cycle by the system.

Test Plan:
- Single call: client 2 say v=0x1234, echo_say_rdy=1 → same cycle echo_say_ena=1, echo_say_v=0x1234, cli_say_rdy[2]=1; next cycle inflight=1. Echo heard v=0x1234 → cli_heard_ena=0b0100, inflight returns to 0.
- Round robin: clients 0,1,3 all assert say continuously → grants go 0,1,3,0 on consecutive cycles; rr_ptr after the 4th grant = 1.
- Full: 4 grants with no indications → inflight=4 and all cli_*_rdy=0. In the cycle a heard pops, a pending request is still refused; it is granted the next cycle.
- Order/mismatch: client 1 say2 (a=5, b=6), then client 0 say. Drive heard first → echo_heard_rdy=0. Drive heard2 → routed to client 1; then heard → routed to client 0.
- Backpressure: head id=3, cli_heard_rdy[3]=0 → echo_heard_rdy=0 and FIFO unchanged; raise rdy → pop.
- Reset with inflight=3 → next cycle inflight=0, rr_ptr=0, echo_heard_rdy=0.

Source files
------------

// File: rtl/echo_request_arbiter.sv
// echo_request_arbiter
//
// Shares one Echo request/indication port pair between NUM_CLIENTS requesters.
//
// Request side: a round-robin arbiter picks one requesting client per cycle.
// The winner's say (or, if it has no say pending, its say2) call is forwarded
// combinationally to the Echo request port.
//
// Response side: every granted call pushes {client id, kind} into an in-order
// tag FIFO. Echo's heard/heard2 indications are steered back to the client
// recorded at the FIFO head, provided the indication kind matches the head
// kind.
//
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   cli_say_ena/_v, cli_say_rdy     per-client say method (payload packed 32/client)
//   cli_say2_ena/_a/_b, cli_say2_rdy per-client say2 method (payload packed 16/client)
//   echo_say_ena/_v, echo_say_rdy   shared Echo say request
//   echo_say2_ena/_a/_b, _rdy       shared Echo say2 request
//   echo_heard_ena/_v, _rdy         Echo heard indication in
//   echo_heard2_ena/_a/_b, _rdy     Echo heard2 indication in
//   cli_heard_ena/_v, cli_heard_rdy per-client heard out (payload broadcast)
//   cli_heard2_ena/_a/_b, _rdy      per-client heard2 out (payload broadcast)
//   inflight                        registered count of outstanding calls
module echo_request_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                        CLK,
  input  logic                        RST,

  input  logic [NUM_CLIENTS-1:0]      cli_say_ena,
  input  logic [32*NUM_CLIENTS-1:0]   cli_say_v,
  output logic [NUM_CLIENTS-1:0]      cli_say_rdy,
  input  logic [NUM_CLIENTS-1:0]      cli_say2_ena,
  input  logic [16*NUM_CLIENTS-1:0]   cli_say2_a,
  input  logic [16*NUM_CLIENTS-1:0]   cli_say2_b,
  output logic [NUM_CLIENTS-1:0]      cli_say2_rdy,

  output logic                        echo_say_ena,
  output logic [31:0]                 echo_say_v,
  input  logic                        echo_say_rdy,
  output logic                        echo_say2_ena,
  output logic [15:0]                 echo_say2_a,
  output logic [15:0]                 echo_say2_b,
  input  logic                        echo_say2_rdy,

  input  logic                        echo_heard_ena,
  input  logic [31:0]                 echo_heard_v,
  output logic                        echo_heard_rdy,
  input  logic                        echo_heard2_ena,
  input  logic [15:0]                 echo_heard2_a,
  input  logic [15:0]                 echo_heard2_b,
  output logic                        echo_heard2_rdy,

  output logic [NUM_CLIENTS-1:0]      cli_heard_ena,
  output logic [31:0]                 cli_heard_v,
  input  logic [NUM_CLIENTS-1:0]      cli_heard_rdy,
  output logic [NUM_CLIENTS-1:0]      cli_heard2_ena,
  output logic [15:0]                 cli_heard2_a,
  output logic [15:0]                 cli_heard2_b,
  input  logic [NUM_CLIENTS-1:0]      cli_heard2_rdy,

  output logic [$clog2(TAG_DEPTH):0]  inflight
);

  localparam int IDW = $clog2(NUM_CLIENTS);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

  // Next round-robin start: the client after the winner, wrapping at NUM_CLIENTS
  // (NUM_CLIENTS need not be a power of two).
  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] w);
    if (int'(w) == NUM_CLIENTS - 1) return '0;
    return w + IDW'(1);
  endfunction

  // Control state
  logic [IDW-1:0] rr_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // Tag FIFO storage (contents are qualified by count, so no reset needed)
  logic [IDW-1:0] tag_id   [TAG_DEPTH];
  logic           tag_kind [TAG_DEPTH];

  // Unpacked per-client payload views
  logic [31:0] say_v_arr  [NUM_CLIENTS];
  logic [15:0] say2_a_arr [NUM_CLIENTS];
  logic [15:0] say2_b_arr [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign say_v_arr[g]  = cli_say_v[32*g +: 32];
    assign say2_a_arr[g] = cli_say2_a[16*g +: 16];
    assign say2_b_arr[g] = cli_say2_b[16*g +: 16];
  end

  logic [NUM_CLIENTS-1:0] req;
  logic                   any_req;
  logic [IDW-1:0]         winner;
  logic [IDW-1:0]         scan_idx;
  logic                   full;
  logic                   empty;
  logic                   win_say;
  logic                   win_say2;
  logic                   say_fire;
  logic                   say2_fire;
  logic                   push;
  logic                   pop;
  logic [IDW-1:0]         head_id;
  logic                   head_kind;

  assign req   = cli_say_ena | cli_say2_ena;
  // Both flags come from the registered count: a pop this cycle cannot
  // make room for a grant this cycle.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Round-robin scan. Walking offsets from highest to lowest lets the
  // closest requester to rr_ptr overwrite any farther one.
  always_comb begin
    any_req  = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NUM_CLIENTS);
      if (req[scan_idx]) begin
        any_req = 1'b1;
        winner  = scan_idx;
      end
    end
  end

  // Say has priority inside the winning client; say2 only goes when the
  // winner has no say pending. A winner whose downstream port is not ready
  // simply stalls; no other client is substituted.
  assign win_say  = any_req && cli_say_ena[winner];
  assign win_say2 = any_req && !cli_say_ena[winner] && cli_say2_ena[winner];

  // Downstream enables never look at the downstream ready.
  assign echo_say_ena  = win_say  && !full;
  assign echo_say2_ena = win_say2 && !full;

  assign echo_say_v  = echo_say_ena  ? say_v_arr[winner]  : '0;
  assign echo_say2_a = echo_say2_ena ? say2_a_arr[winner] : '0;
  assign echo_say2_b = echo_say2_ena ? say2_b_arr[winner] : '0;

  assign say_fire  = echo_say_ena  && echo_say_rdy;
  assign say2_fire = echo_say2_ena && echo_say2_rdy;
  assign push      = say_fire || say2_fire;

  assign head_id   = tag_id[rd_ptr];
  assign head_kind = tag_kind[rd_ptr];

  // An indication whose kind does not match the head is held off (rdy low)
  // until the matching kind arrives.
  assign echo_heard_rdy  = !empty && !head_kind && cli_heard_rdy[head_id];
  assign echo_heard2_rdy = !empty &&  head_kind && cli_heard2_rdy[head_id];

  // Kinds are exclusive at the head, so at most one of these can fire.
  assign pop = (echo_heard_ena && echo_heard_rdy) || (echo_heard2_ena && echo_heard2_rdy);

  assign cli_heard_v  = echo_heard_v;
  assign cli_heard2_a = echo_heard2_a;
  assign cli_heard2_b = echo_heard2_b;

  always_comb begin
    cli_say_rdy    = '0;
    cli_say2_rdy   = '0;
    cli_heard_ena  = '0;
    cli_heard2_ena = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (any_req && (int'(winner) == i) && !full) begin
        cli_say_rdy[i]  = echo_say_rdy;
        cli_say2_rdy[i] = !cli_say_ena[i] && echo_say2_rdy;
      end
      if (!empty && (int'(head_id) == i)) begin
        cli_heard_ena[i]  = echo_heard_ena  && !head_kind;
        cli_heard2_ena[i] = echo_heard2_ena &&  head_kind;
      end
    end
  end

  // Tag FIFO write port
  always_ff @(posedge CLK) begin
    if (push) begin
      tag_id[wr_ptr]   <= winner;
      tag_kind[wr_ptr] <= say2_fire;
    end
  end

  // Pointers, occupancy and arbitration state
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rr_ptr <= rr_next(winner);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign inflight = count;

endmodule

// File: tb/tb_echo_request_arbiter.sv
module tb_echo_request_arbiter;

  localparam int N       = 4;
  localparam int D       = 4;
  localparam int NCYC    = 3000;
  localparam int RST_CYC = 1500;

  logic                CLK = 1'b0;
  logic                RST;
  logic [N-1:0]        cli_say_ena;
  logic [32*N-1:0]     cli_say_v;
  logic [N-1:0]        cli_say_rdy;
  logic [N-1:0]        cli_say2_ena;
  logic [16*N-1:0]     cli_say2_a;
  logic [16*N-1:0]     cli_say2_b;
  logic [N-1:0]        cli_say2_rdy;
  logic                echo_say_ena;
  logic [31:0]         echo_say_v;
  logic                echo_say_rdy;
  logic                echo_say2_ena;
  logic [15:0]         echo_say2_a;
  logic [15:0]         echo_say2_b;
  logic                echo_say2_rdy;
  logic                echo_heard_ena;
  logic [31:0]         echo_heard_v;
  logic                echo_heard_rdy;
  logic                echo_heard2_ena;
  logic [15:0]         echo_heard2_a;
  logic [15:0]         echo_heard2_b;
  logic                echo_heard2_rdy;
  logic [N-1:0]        cli_heard_ena;
  logic [31:0]         cli_heard_v;
  logic [N-1:0]        cli_heard_rdy;
  logic [N-1:0]        cli_heard2_ena;
  logic [15:0]         cli_heard2_a;
  logic [15:0]         cli_heard2_b;
  logic [N-1:0]        cli_heard2_rdy;
  logic [$clog2(D):0]  inflight;

  echo_request_arbiter #(.NUM_CLIENTS(N), .TAG_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST),
    .cli_say_ena(cli_say_ena), .cli_say_v(cli_say_v), .cli_say_rdy(cli_say_rdy),
    .cli_say2_ena(cli_say2_ena), .cli_say2_a(cli_say2_a), .cli_say2_b(cli_say2_b),
    .cli_say2_rdy(cli_say2_rdy),
    .echo_say_ena(echo_say_ena), .echo_say_v(echo_say_v), .echo_say_rdy(echo_say_rdy),
    .echo_say2_ena(echo_say2_ena), .echo_say2_a(echo_say2_a), .echo_say2_b(echo_say2_b),
    .echo_say2_rdy(echo_say2_rdy),
    .echo_heard_ena(echo_heard_ena), .echo_heard_v(echo_heard_v), .echo_heard_rdy(echo_heard_rdy),
    .echo_heard2_ena(echo_heard2_ena), .echo_heard2_a(echo_heard2_a), .echo_heard2_b(echo_heard2_b),
    .echo_heard2_rdy(echo_heard2_rdy),
    .cli_heard_ena(cli_heard_ena), .cli_heard_v(cli_heard_v), .cli_heard_rdy(cli_heard_rdy),
    .cli_heard2_ena(cli_heard2_ena), .cli_heard2_a(cli_heard2_a), .cli_heard2_b(cli_heard2_b),
    .cli_heard2_rdy(cli_heard2_rdy),
    .inflight(inflight)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    bit          kind;   // 0 = say, 1 = say2
    logic [31:0] v;
    logic [15:0] a;
    logic [15:0] b;
  } call_t;

  call_t tagq[$];    // reference model: outstanding calls in issue order
  call_t req_q[$];   // expected grants for the monitor
  call_t resp_q[$];  // expected routed indications for the monitor

  int rr           = 0;
  int exp_inflight = 0;
  bit mon_en       = 1'b0;
  bit rst_now      = 1'b0;
  int checks       = 0;
  int failures     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    cli_say_ena     = '0;
    cli_say2_ena    = '0;
    cli_say_v       = '0;
    cli_say2_a      = '0;
    cli_say2_b      = '0;
    echo_heard_ena  = 1'b0;
    echo_heard2_ena = 1'b0;
    echo_heard_v    = '0;
    echo_heard2_a   = '0;
    echo_heard2_b   = '0;
  endtask

  // Randomize one cycle of stimulus and derive the expected behaviour from
  // the arbitration and routing rules applied to the queue model.
  task automatic drive_and_model(input int cyc);
    logic [N-1:0] say, say2;
    logic [31:0]  sv  [N];
    logic [15:0]  sa  [N];
    logic [15:0]  sb  [N];
    int           hp, win, j;
    bit           k, pop, granted, gk;
    call_t        head, c;

    case ((cyc / 200) % 3)
      0:       hp = 10;
      1:       hp = 50;
      default: hp = 90;
    endcase

    for (int i = 0; i < N; i++) begin
      say[i]  = ($urandom_range(99) < 35);
      say2[i] = ($urandom_range(99) < 35);
      sv[i]   = $urandom();
      sa[i]   = 16'($urandom());
      sb[i]   = 16'($urandom());
      cli_say_v[32*i +: 32]  = sv[i];
      cli_say2_a[16*i +: 16] = sa[i];
      cli_say2_b[16*i +: 16] = sb[i];
      cli_heard_rdy[i]  = ($urandom_range(99) < 70);
      cli_heard2_rdy[i] = ($urandom_range(99) < 70);
    end
    cli_say_ena   = say;
    cli_say2_ena  = say2;
    echo_say_rdy  = ($urandom_range(99) < 80);
    echo_say2_rdy = ($urandom_range(99) < 80);

    echo_heard_ena  = 1'b0;
    echo_heard2_ena = 1'b0;
    echo_heard_v    = $urandom();
    echo_heard2_a   = 16'($urandom());
    echo_heard2_b   = 16'($urandom());
    if (tagq.size() > 0 && $urandom_range(99) < hp) begin
      head = tagq[0];
      k = head.kind;
      if ($urandom_range(99) < 20) k = !k;   // deliberately wrong kind
      if (!k) begin
        echo_heard_ena = 1'b1;
        if (k == head.kind) echo_heard_v = head.v;
      end else begin
        echo_heard2_ena = 1'b1;
        if (k == head.kind) begin
          echo_heard2_a = head.a;
          echo_heard2_b = head.b;
        end
      end
    end

    // Response: the oldest outstanding call is delivered only when the
    // matching indication kind is present and its owner is ready.
    pop = 1'b0;
    if (tagq.size() > 0) begin
      head = tagq[0];
      if (!head.kind && echo_heard_ena && cli_heard_rdy[head.id]) begin
        c = head;
        c.v = echo_heard_v;
        resp_q.push_back(c);
        pop = 1'b1;
      end else if (head.kind && echo_heard2_ena && cli_heard2_rdy[head.id]) begin
        c = head;
        c.a = echo_heard2_a;
        c.b = echo_heard2_b;
        resp_q.push_back(c);
        pop = 1'b1;
      end
    end

    // Request: first requester from rr onward; fullness from pre-cycle occupancy.
    win = -1;
    for (int o = 0; o < N; o++) begin
      j = (rr + o) % N;
      if (say[j] || say2[j]) begin
        win = j;
        break;
      end
    end
    granted = 1'b0;
    gk      = 1'b0;
    if (win >= 0 && tagq.size() < D) begin
      if (say[win]) begin
        if (echo_say_rdy) granted = 1'b1;
      end else if (echo_say2_rdy) begin
        granted = 1'b1;
        gk      = 1'b1;
      end
    end
    if (granted) begin
      c.id   = win;
      c.kind = gk;
      c.v    = sv[win];
      c.a    = sa[win];
      c.b    = sb[win];
      req_q.push_back(c);
      rr = (win + 1) % N;
    end

    if (pop) void'(tagq.pop_front());
    if (granted) tagq.push_back(c);
  endtask

  task automatic monitor_cycle();
    logic [N-1:0] sacc, s2acc, hacc, h2acc, exp1, exp2;
    logic         sfire, s2fire, hfire, h2fire;
    call_t        e;

    sacc   = cli_say_ena & cli_say_rdy;
    s2acc  = cli_say2_ena & cli_say2_rdy;
    hacc   = cli_heard_ena & cli_heard_rdy;
    h2acc  = cli_heard2_ena & cli_heard2_rdy;
    sfire  = echo_say_ena && echo_say_rdy;
    s2fire = echo_say2_ena && echo_say2_rdy;
    hfire  = echo_heard_ena && echo_heard_rdy;
    h2fire = echo_heard2_ena && echo_heard2_rdy;

    check("say_ena_exclusive", {echo_say_ena, echo_say2_ena} == 2'b11, 1'b0);
    check("inflight", inflight, exp_inflight);
    check("heard_pop_vs_route", hfire, hacc != '0);
    check("heard2_pop_vs_route", h2fire, h2acc != '0);

    if (sfire || s2fire || sacc != '0 || s2acc != '0) begin
      if (req_q.size() == 0) begin
        check("grant_unexpected", req_q.size(), 1);
      end else begin
        e = req_q.pop_front();
        exp1 = e.kind ? '0 : (N'(1) << e.id);
        exp2 = e.kind ? (N'(1) << e.id) : '0;
        check("echo_say_fire", sfire, !e.kind);
        check("echo_say2_fire", s2fire, e.kind);
        check("cli_say_accept", sacc, exp1);
        check("cli_say2_accept", s2acc, exp2);
        if (!e.kind) check("echo_say_v", echo_say_v, e.v);
        else         check("echo_say2_ab", {echo_say2_a, echo_say2_b}, {e.a, e.b});
      end
    end
    if (req_q.size() != 0) begin
      check("grant_missing", req_q.size(), 0);
      req_q.delete();
    end

    if (hacc != '0 || h2acc != '0) begin
      if (resp_q.size() == 0) begin
        check("route_unexpected", resp_q.size(), 1);
      end else begin
        e = resp_q.pop_front();
        exp1 = e.kind ? '0 : (N'(1) << e.id);
        exp2 = e.kind ? (N'(1) << e.id) : '0;
        check("cli_heard_route", hacc, exp1);
        check("cli_heard2_route", h2acc, exp2);
        if (!e.kind) check("cli_heard_v", cli_heard_v, e.v);
        else         check("cli_heard2_ab", {cli_heard2_a, cli_heard2_b}, {e.a, e.b});
      end
    end
    if (resp_q.size() != 0) begin
      check("route_missing", resp_q.size(), 0);
      resp_q.delete();
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) monitor_cycle();
    end
  end

  initial begin
    RST = 1'b1;
    clear_inputs();
    echo_say_rdy   = 1'b1;
    echo_say2_rdy  = 1'b1;
    cli_heard_rdy  = '1;
    cli_heard2_rdy = '1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_cli_say_rdy", cli_say_rdy, '0);
    check("rst_cli_say2_rdy", cli_say2_rdy, '0);
    check("rst_echo_say_ena", echo_say_ena, 1'b0);
    check("rst_echo_say2_ena", echo_say2_ena, 1'b0);
    check("rst_echo_heard_rdy", echo_heard_rdy, 1'b0);
    check("rst_echo_heard2_rdy", echo_heard2_rdy, 1'b0);
    check("rst_cli_heard_ena", cli_heard_ena, '0);
    check("rst_cli_heard2_ena", cli_heard2_ena, '0);
    check("rst_inflight", inflight, 0);
    mon_en = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge CLK);
      #1;
      if (rst_now) begin
        tagq.delete();
        rr = 0;
      end
      rst_now      = (cyc == RST_CYC);
      RST          = rst_now;
      exp_inflight = tagq.size();
      if (rst_now) clear_inputs();
      else         drive_and_model(cyc);
    end

    @(posedge CLK);
    #1;
    if (rst_now) begin
      tagq.delete();
      rr = 0;
    end
    RST = 1'b0;
    exp_inflight = tagq.size();
    clear_inputs();
    repeat (2) @(negedge CLK);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
